plugboard_config_ctrl: RTL

- Owns the plugboard swap table: the configuration FSM plus the run-time substitution path.
- In config mode it takes one-hot letter keystrokes from the keyboard decoder and pairs them (up to MAX_PAIRS).
- Pressing an already-plugged letter removes its pair. A multi-cycle walk clears the whole table.
- In run mode it maps each one-hot keyboard letter through the table before it reaches the rotor/reflector stage (rero).

---
 rtl/plugboard_pkg.sv | 47 ++++
 rtl/letter_onehot_enc.sv | 13 +
 rtl/plugboard_config_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/plugboard_pkg.sv
// Shared types, constants and letter-encoding helpers for the plugboard swap table.
package plugboard_pkg;

    localparam int unsigned N_LETTERS = 26;
    localparam int unsigned IDX_W     = 5;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_FIRST  = 2'd1,
        S_SECOND = 2'd2,
        S_CLEAR  = 2'd3
    } state_e;

    localparam logic [1:0] ERR_FULL   = 2'd1;
    localparam logic [1:0] ERR_BUSY   = 2'd2;
    localparam logic [1:0] ERR_BADKEY = 2'd3;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    function automatic logic onehot_valid(input logic [N_LETTERS-1:0] oh);
        logic [N_LETTERS-1:0] low_cleared;
        low_cleared = oh & (oh - {{(N_LETTERS-1){1'b0}}, 1'b1});
        return (oh != '0) && (low_cleared == '0);
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_LETTERS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_LETTERS; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [N_LETTERS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_LETTERS-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_LETTERS; i++) begin
            if (idx == IDX_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/letter_onehot_enc.sv
// One-hot letter to 5-bit index; valid only when exactly one bit is set.
module letter_onehot_enc
    import plugboard_pkg::*;
(
    input  logic [N_LETTERS-1:0] letter,
    output logic [IDX_W-1:0]     idx,
    output logic                 valid
);

    assign idx   = onehot_to_idx(letter);
    assign valid = onehot_valid(letter);

endmodule

// File: rtl/plugboard_config_ctrl.sv
// Plugboard swap table: configuration FSM (pair/unplug/clear) and the run-mode
// one-cycle letter substitution path.
module plugboard_config_ctrl
    import plugboard_pkg::*;
#(
    parameter int unsigned MAX_PAIRS = 10
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 cfg_mode,
    input  logic                 key_valid,
    input  logic [N_LETTERS-1:0] key_letter,
    input  logic                 clear_all,
    input  logic [N_LETTERS-1:0] data_in,
    input  logic                 data_in_valid,
    output logic [N_LETTERS-1:0] data_out,
    output logic                 data_out_valid,
    output logic [3:0]           pair_count,
    output logic [N_LETTERS-1:0] pending_letter,
    output logic [1:0]           fsm_state,
    output logic                 err,
    output logic [1:0]           err_code
);

    state_e           state_q;
    logic [IDX_W-1:0] map_q [N_LETTERS];
    logic [IDX_W-1:0] clr_idx_q;

    logic [IDX_W-1:0] key_idx;
    logic             key_ok;
    logic [IDX_W-1:0] din_idx;
    logic             din_ok;
    logic [IDX_W-1:0] key_partner;
    logic             key_plugged;
    logic [IDX_W-1:0] pending_idx;

    letter_onehot_enc u_key_enc (
        .letter (key_letter),
        .idx    (key_idx),
        .valid  (key_ok)
    );

    letter_onehot_enc u_din_enc (
        .letter (data_in),
        .idx    (din_idx),
        .valid  (din_ok)
    );

    assign key_partner = map_q[key_idx];
    assign key_plugged = (key_partner != key_idx);
    assign pending_idx = onehot_to_idx(pending_letter);
    assign fsm_state   = state_q;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q        <= S_RUN;
            clr_idx_q      <= '0;
            pair_count     <= '0;
            pending_letter <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            err            <= 1'b0;
            err_code       <= '0;
            for (int i = 0; i < N_LETTERS; i++) begin
                map_q[i] <= IDX_W'(i);
            end
        end else begin
            err            <= 1'b0;
            data_out_valid <= 1'b0;

            // data_out holds its last value whenever no letter is substituted.
            if (state_q == S_RUN && data_in_valid) begin
                data_out       <= din_ok ? idx_to_onehot(map_q[din_idx]) : '0;
                data_out_valid <= 1'b1;
            end

            // A clear already in progress ignores further clear_all strobes.
            if (clear_all && state_q != S_CLEAR) begin
                state_q   <= S_CLEAR;
                clr_idx_q <= '0;
            end else begin
                unique case (state_q)
                    S_RUN: begin
                        if (cfg_mode) begin
                            state_q <= S_FIRST;
                        end
                    end

                    S_FIRST: begin
                        if (!cfg_mode) begin
                            state_q        <= S_RUN;
                            pending_letter <= '0;
                        end else if (key_valid) begin
                            if (!key_ok) begin
                                err      <= 1'b1;
                                err_code <= ERR_BADKEY;
                            end else if (key_plugged) begin
                                map_q[key_idx]     <= key_idx;
                                map_q[key_partner] <= key_partner;
                                pair_count         <= pair_count - 4'd1;
                            end else if (pair_count == 4'(MAX_PAIRS)) begin
                                err      <= 1'b1;
                                err_code <= ERR_FULL;
                            end else begin
                                pending_letter <= key_letter;
                                state_q        <= S_SECOND;
                            end
                        end
                    end

                    S_SECOND: begin
                        if (!cfg_mode) begin
                            state_q        <= S_RUN;
                            pending_letter <= '0;
                        end else if (key_valid) begin
                            if (!key_ok) begin
                                err      <= 1'b1;
                                err_code <= ERR_BADKEY;
                            end else if (key_letter == pending_letter) begin
                                pending_letter <= '0;
                                state_q        <= S_FIRST;
                            end else if (key_plugged) begin
                                err      <= 1'b1;
                                err_code <= ERR_BUSY;
                            end else begin
                                map_q[pending_idx] <= key_idx;
                                map_q[key_idx]     <= pending_idx;
                                pair_count         <= pair_count + 4'd1;
                                pending_letter     <= '0;
                                state_q            <= S_FIRST;
                            end
                        end
                    end

                    S_CLEAR: begin
                        map_q[clr_idx_q] <= clr_idx_q;
                        clr_idx_q        <= clr_idx_q + 5'd1;
                        if (clr_idx_q == IDX_W'(N_LETTERS - 1)) begin
                            pair_count     <= '0;
                            pending_letter <= '0;
                            state_q        <= cfg_mode ? S_FIRST : S_RUN;
                        end
                    end

                    default: state_q <= S_RUN;
                endcase
            end
        end
    end

endmodule
